ram_port_arbiter: RTL and testbench

Arbiter for data port 1 of the 16x128 two-port RAM (`ram_rw_2p_16x128`), sharing it between two requesters: master 0 (processor data accesses) and master 1 (host loader/debug access that fills and dumps RAM while the processor runs). It sequences one access per cycle, supports locked bursts with a hard length cap, and routes the one-cycle-latency read data back to the issuing master. Port 0 (program fetch) is untouched.

---
 rtl/ram_arb_pkg.sv | 28 ++
 rtl/ram_arb_ret.sv | 49 ++++
 rtl/ram_port_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
//   Shared types and defaults for the RAM port-1 arbiter.
//   - arb_state_t : arbiter ownership state (IDLE / OWN0 / OWN1)
//   - master_t    : master index (0 = processor data, 1 = host loader/debug)
//   - DEF_ADDR_W / DEF_DATA_W : default geometry of the 16x128 RAM
package ram_arb_pkg;

  localparam int DEF_ADDR_W  = 7;
  localparam int DEF_DATA_W  = 16;
  localparam int NUM_MASTERS = 2;

  typedef logic master_t;

  localparam master_t M0 = 1'b0;
  localparam master_t M1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  // Ownership state that corresponds to a locked grant for master m.
  function automatic arb_state_t own_state(input master_t m);
    return (m == M1) ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/ram_arb_ret.sv
// ram_arb_ret
//   One-stage read-return tracker. The RAM returns read data one cycle after
//   the read strobe, so it is enough to remember whether the previous cycle
//   issued a read and for which master, then steer ram_dout to that master.
// Ports:
//   clk, reset   : clock, asynchronous active-high reset
//   issue_rd     : a read was granted this cycle
//   issue_owner  : master that owns the read granted this cycle
//   ram_dout     : RAM port-1 read data (valid the cycle after issue)
//   rvalid       : per-master read-data-valid
//   rdata        : per-master read data, forced 0 when not valid
module ram_arb_ret
  import ram_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   issue_rd,
  input  master_t                issue_owner,
  input  logic [DATA_W-1:0]      ram_dout,
  output logic [NUM_MASTERS-1:0] rvalid,
  output logic [DATA_W-1:0]      rdata [NUM_MASTERS]
);

  logic    valid_reg;
  master_t owner_reg;

  // Reset clears the pending return immediately, so a read issued before
  // reset never produces an rvalid after release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      owner_reg <= M0;
    end else begin
      valid_reg <= issue_rd;
      owner_reg <= issue_owner;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_ret
      assign rvalid[gi] = valid_reg && (owner_reg == master_t'(gi));
      assign rdata[gi]  = rvalid[gi] ? ram_dout : '0;
    end
  endgenerate

endmodule

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
//   Shares data port 1 of the 16x128 two-port RAM between master 0
//   (processor data) and master 1 (host loader/debug). One access is issued
//   per cycle; a master may lock the port for a burst of at most MAX_BURST
//   consecutive grants, after which the other master gets the next tie.
//   Read data comes back one cycle after the grant on the issuing master.
// Build option:
//   RAM_ARB_ROUND_ROBIN_EN defined   : IDLE ties go to the master that did not
//                                      win last.
//   RAM_ARB_ROUND_ROBIN_EN undefined : IDLE ties go to master 0, except the
//                                      cycle right after a capped burst.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   mX_req/we/lock/addr/wdata  : master X request (held until granted)
//   mX_gnt                     : access issued for master X this cycle
//   mX_rvalid / mX_rdata       : read return for master X (rdata 0 if idle)
//   ram_read_en/write_en/addr/din : RAM port-1 controls (0 with no grant)
//   ram_dout                   : RAM port-1 read data, one cycle latency
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int MAX_BURST = 8,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_read_en,
  output logic              ram_write_en,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  // Per-master request views, indexed by master_t.
  logic [NUM_MASTERS-1:0] req_vec;
  logic [NUM_MASTERS-1:0] we_vec;
  logic [NUM_MASTERS-1:0] lock_vec;
  logic [ADDR_W-1:0]      addr_arr  [NUM_MASTERS];
  logic [DATA_W-1:0]      wdata_arr [NUM_MASTERS];

  assign req_vec      = {m1_req, m0_req};
  assign we_vec       = {m1_we, m0_we};
  assign lock_vec     = {m1_lock, m0_lock};
  assign addr_arr[0]  = m0_addr;
  assign addr_arr[1]  = m1_addr;
  assign wdata_arr[0] = m0_wdata;
  assign wdata_arr[1] = m1_wdata;

  arb_state_t       state_reg;
  logic [CNT_W-1:0] burst_cnt_reg;
  master_t          last_winner_reg;
`ifndef RAM_ARB_ROUND_ROBIN_EN
  logic             yield_reg;    // previous cycle ended a capped burst
`endif

  master_t          owner_idx;
  logic             owner_active;
  master_t          tie_winner;
  logic             gnt_any;
  master_t          gnt_idx;
  logic             sel_we;
  logic             sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [CNT_W-1:0] new_count;
  logic             cap_hit;

  // The owner only keeps the port while it is requesting; a cycle with the
  // owner's req low is arbitrated exactly like IDLE, so the other master can
  // use the slot.
  assign owner_idx    = (state_reg == OWN1) ? M1 : M0;
  assign owner_active = (state_reg != IDLE) && req_vec[owner_idx];

`ifdef RAM_ARB_ROUND_ROBIN_EN
  assign tie_winner = ~last_winner_reg;
`else
  // last_winner_reg holds the capped master when yield_reg is set.
  assign tie_winner = yield_reg ? ~last_winner_reg : M0;
`endif

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = M0;
    if (!reset) begin
      if (owner_active) begin
        gnt_any = 1'b1;
        gnt_idx = owner_idx;
      end else if (req_vec[0] && req_vec[1]) begin
        gnt_any = 1'b1;
        gnt_idx = tie_winner;
      end else if (req_vec[0]) begin
        gnt_any = 1'b1;
        gnt_idx = M0;
      end else if (req_vec[1]) begin
        gnt_any = 1'b1;
        gnt_idx = M1;
      end
    end
  end

  assign sel_we    = we_vec[gnt_idx];
  assign sel_lock  = lock_vec[gnt_idx];
  assign sel_addr  = addr_arr[gnt_idx];
  assign sel_wdata = wdata_arr[gnt_idx];

  // Beat number of this grant within the current burst (1 for a fresh grant).
  assign new_count = owner_active ? (burst_cnt_reg + 1'b1) : CNT_W'(1);
  // A locked sequence that reaches MAX_BURST beats is released regardless of
  // lock; this also covers MAX_BURST = 1, where the opening beat is the cap.
  assign cap_hit   = (owner_active || sel_lock) && (new_count >= CNT_W'(MAX_BURST));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      burst_cnt_reg   <= '0;
      last_winner_reg <= M1;
`ifndef RAM_ARB_ROUND_ROBIN_EN
      yield_reg       <= 1'b0;
`endif
    end else begin
      if (gnt_any) begin
        last_winner_reg <= gnt_idx;
        if (!cap_hit && sel_lock) begin
          state_reg     <= own_state(gnt_idx);
          burst_cnt_reg <= new_count;
        end else begin
          state_reg     <= IDLE;
          burst_cnt_reg <= '0;
        end
      end else begin
        state_reg     <= IDLE;
        burst_cnt_reg <= '0;
      end
`ifndef RAM_ARB_ROUND_ROBIN_EN
      yield_reg <= gnt_any && cap_hit;
`endif
    end
  end

  // Grant fan-out and RAM port drive.
  logic [NUM_MASTERS-1:0] gnt_vec;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_gnt
      assign gnt_vec[gi] = gnt_any && (gnt_idx == master_t'(gi));
    end
  endgenerate

  assign m0_gnt       = gnt_vec[0];
  assign m1_gnt       = gnt_vec[1];
  assign ram_read_en  = gnt_any && !sel_we;
  assign ram_write_en = gnt_any && sel_we;
  assign ram_addr     = gnt_any ? sel_addr  : '0;
  assign ram_din      = gnt_any ? sel_wdata : '0;

  logic [NUM_MASTERS-1:0] rvalid_vec;
  logic [DATA_W-1:0]      rdata_arr [NUM_MASTERS];

  ram_arb_ret #(
    .DATA_W (DATA_W)
  ) u_ret (
    .clk         (clk),
    .reset       (reset),
    .issue_rd    (ram_read_en),
    .issue_owner (gnt_idx),
    .ram_dout    (ram_dout),
    .rvalid      (rvalid_vec),
    .rdata       (rdata_arr)
  );

  assign m0_rvalid = rvalid_vec[0];
  assign m1_rvalid = rvalid_vec[1];
  assign m0_rdata  = rdata_arr[0];
  assign m1_rdata  = rdata_arr[1];

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb_ram_port_arbiter
//   Directed then randomized stimulus for ram_port_arbiter. Each master is a
//   queue of transactions whose head is presented until granted; a 128-word
//   RAM model answers port 1, and a reference model built from the
//   arbitration rules predicts every grant, RAM strobe and read return.
module tb_ram_port_arbiter;

  localparam int MAX_BURST = 8;
  localparam int ADDR_W    = 7;
  localparam int DATA_W    = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata;
  logic              ram_read_en, ram_write_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  always #5 clk = ~clk;

  ram_port_arbiter #(
    .MAX_BURST (MAX_BURST),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_req       (m0_req),
    .m0_we        (m0_we),
    .m0_lock      (m0_lock),
    .m0_addr      (m0_addr),
    .m0_wdata     (m0_wdata),
    .m1_req       (m1_req),
    .m1_we        (m1_we),
    .m1_lock      (m1_lock),
    .m1_addr      (m1_addr),
    .m1_wdata     (m1_wdata),
    .m0_gnt       (m0_gnt),
    .m1_gnt       (m1_gnt),
    .m0_rvalid    (m0_rvalid),
    .m1_rvalid    (m1_rvalid),
    .m0_rdata     (m0_rdata),
    .m1_rdata     (m1_rdata),
    .ram_read_en  (ram_read_en),
    .ram_write_en (ram_write_en),
    .ram_addr     (ram_addr),
    .ram_din      (ram_din),
    .ram_dout     (ram_dout)
  );

  // RAM port-1 model: one-cycle read latency.
  logic [DATA_W-1:0] mem [128];
  always @(posedge clk) begin
    if (ram_write_en === 1'b1) mem[ram_addr] <= ram_din;
    if (ram_read_en === 1'b1) ram_dout <= mem[ram_addr];
  end

  typedef struct {
    bit              gap;    // present req=0 for one cycle
    bit              we;
    bit              lock;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  txn_t q0[$];
  txn_t q1[$];
  int   gnt_log[$];

  int checks = 0;
  int errors = 0;

  // Reference model: who holds a locked burst, how many beats it has had,
  // who won last, whether the loser of a capped burst is owed the next tie.
  int                own;
  int                beats;
  int                last;
  bit                favour;
  int                rv_own;
  logic [DATA_W-1:0] rv_data;
  logic [DATA_W-1:0] shadow [128];
  logic [DATA_W-1:0] last_rd0, last_rd1;

  function automatic txn_t mk(input bit we, input bit lock, input int addr, input int data);
    txn_t t;
    t.gap   = 1'b0;
    t.we    = we;
    t.lock  = lock;
    t.addr  = ADDR_W'(addr);
    t.wdata = DATA_W'(data);
    return t;
  endfunction

  function automatic txn_t gap_txn();
    txn_t t;
    t = mk(1'b0, 1'b0, 0, 0);
    t.gap = 1'b1;
    return t;
  endfunction

  function automatic txn_t rnd_txn();
    if ($urandom_range(0, 9) == 0) return gap_txn();
    return mk(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 65535)));
  endfunction

  function automatic int pick(input bit r0, input bit r1);
    if (own == 0 && r0) return 0;
    if (own == 1 && r1) return 1;
    if (r0 && r1) begin
`ifdef RAM_ARB_ROUND_ROBIN_EN
      return 1 - last;
`else
      return favour ? 1 - last : 0;
`endif
    end
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic model_reset();
    own    = -1;
    beats  = 0;
    last   = 1;
    favour = 1'b0;
    rv_own = -1;
    rv_data = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m0_gnt"}, 32'(m0_gnt), 32'd0);
    chk({tag, "_m1_gnt"}, 32'(m1_gnt), 32'd0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    chk({tag, "_m0_rdata"}, 32'(m0_rdata), 32'd0);
    chk({tag, "_m1_rdata"}, 32'(m1_rdata), 32'd0);
    chk({tag, "_ram_read_en"}, 32'(ram_read_en), 32'd0);
    chk({tag, "_ram_write_en"}, 32'(ram_write_en), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_ram_din"}, 32'(ram_din), 32'd0);
  endtask

  // One clock: present queue heads, check outputs, advance model at the edge.
  // Entered and left 1 time unit after a rising edge.
  task automatic cycle();
    txn_t h0, h1, sel;
    bit   r0, r1, g0, g1;
    int   w, beats_now;
    h0 = mk(1'b0, 1'b0, 0, 0);
    h1 = h0;
    sel = h0;
    if (q0.size() > 0) h0 = q0[0];
    if (q1.size() > 0) h1 = q1[0];
    g0 = (q0.size() > 0) && h0.gap;
    g1 = (q1.size() > 0) && h1.gap;
    r0 = (q0.size() > 0) && !h0.gap;
    r1 = (q1.size() > 0) && !h1.gap;
    m0_req = r0; m0_we = h0.we; m0_lock = h0.lock; m0_addr = h0.addr; m0_wdata = h0.wdata;
    m1_req = r1; m1_we = h1.we; m1_lock = h1.lock; m1_addr = h1.addr; m1_wdata = h1.wdata;
    #1;
    w = pick(r0, r1);
    if (w == 0) sel = h0;
    if (w == 1) sel = h1;
    chk("m0_gnt", 32'(m0_gnt), 32'(w == 0));
    chk("m1_gnt", 32'(m1_gnt), 32'(w == 1));
    chk("ram_read_en", 32'(ram_read_en), 32'(w >= 0 && !sel.we));
    chk("ram_write_en", 32'(ram_write_en), 32'(w >= 0 && sel.we));
    chk("ram_addr", 32'(ram_addr), (w >= 0) ? 32'(sel.addr) : 32'd0);
    chk("ram_din", 32'(ram_din), (w >= 0) ? 32'(sel.wdata) : 32'd0);
    chk("m0_rvalid", 32'(m0_rvalid), 32'(rv_own == 0));
    chk("m1_rvalid", 32'(m1_rvalid), 32'(rv_own == 1));
    chk("m0_rdata", 32'(m0_rdata), (rv_own == 0) ? 32'(rv_data) : 32'd0);
    chk("m1_rdata", 32'(m1_rdata), (rv_own == 1) ? 32'(rv_data) : 32'd0);
    if (m0_rvalid === 1'b1) last_rd0 = m0_rdata;
    if (m1_rvalid === 1'b1) last_rd1 = m1_rdata;
    gnt_log.push_back(w);
    @(posedge clk);
    rv_own = -1;
    if (w >= 0) begin
      if (sel.we) shadow[sel.addr] = sel.wdata;
      else begin
        rv_own  = w;
        rv_data = shadow[sel.addr];
      end
      beats_now = (own == w) ? beats + 1 : 1;
      if ((own == w || sel.lock) && beats_now >= MAX_BURST) begin
        own = -1; beats = 0; favour = 1'b1;
      end else if (sel.lock) begin
        own = w; beats = beats_now; favour = 1'b0;
      end else begin
        own = -1; beats = 0; favour = 1'b0;
      end
      last = w;
      if (w == 0) void'(q0.pop_front());
      else void'(q1.pop_front());
    end else begin
      own = -1; beats = 0; favour = 1'b0;
    end
    if (g0) void'(q0.pop_front());
    if (g1) void'(q1.pop_front());
    #1;
  endtask

  task automatic run(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    assert (q0.size() == 0 && q1.size() == 0) else begin
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", q0.size() + q1.size());
    end
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    for (int i = 0; i < 128; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    ram_dout = '0;
    m0_req = 1'b1; m0_we = 1'b0; m0_lock = 1'b1; m0_addr = 7'd5; m0_wdata = '0;
    m1_req = 1'b1; m1_we = 1'b1; m1_lock = 1'b0; m1_addr = 7'd9; m1_wdata = 16'h5555;
    model_reset();

    // Reset: everything 0 even with both masters requesting.
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    reset = 1'b0;

    // m1 stores 0x1234 at 5, then m0 reads it back.
    q1.push_back(mk(1'b1, 1'b0, 5, 16'h1234));
    run(4);
    last_rd0 = '0;
    q0.push_back(mk(1'b0, 1'b0, 5, 0));
    run(4);
    cycle();
    chk("m0_rdata_1234", 32'(last_rd0), 32'h1234);
    $display("txn read addr5 m0 rdata=%h", last_rd0);

    // Both masters request unlocked every cycle.
    gnt_log.delete();
    for (int i = 0; i < 6; i++) begin
      q0.push_back(mk(1'b0, 1'b0, int'($urandom_range(0, 127)), 0));
      q1.push_back(mk(1'b0, 1'b0, int'($urandom_range(0, 127)), 0));
    end
    run(20);
    cnt = 0;
    for (int i = 0; i < 6; i++) if (gnt_log[i] == 0) cnt++;
`ifdef RAM_ARB_ROUND_ROBIN_EN
    chk("tie_m0_share_first6", 32'(cnt), 32'd3);
`else
    chk("tie_m0_share_first6", 32'(cnt), 32'd6);
`endif
    $display("txn contention m0 grants in first 6 cycles=%0d", cnt);

    // m0 locked burst of 12 writes while m1 waits with a read.
    gnt_log.delete();
    for (int i = 0; i < 12; i++) q0.push_back(mk(1'b1, i < 11, i, i));
    cycle();
    q1.push_back(mk(1'b0, 1'b0, 3, 0));
    run(40);
    cnt = 0;
    for (int i = 0; i < 8; i++) if (gnt_log[i] == 0) cnt++;
    chk("burst_m0_beats", 32'(cnt), 32'd8);
    chk("burst_m1_on_9th", 32'(gnt_log[8]), 32'd1);
    chk("burst_m0_resumes", 32'(gnt_log[9]), 32'd0);
    $display("txn burst m0 beats before m1=%0d m1 slot=%0d", cnt, gnt_log[8]);

    // m1 writes 0xBEEF at 127, m0 reads it on the next cycle.
    last_rd0 = '0;
    q1.push_back(mk(1'b1, 1'b0, 127, 16'hBEEF));
    cycle();
    q0.push_back(mk(1'b0, 1'b0, 127, 0));
    cycle();
    cycle();
    chk("m0_rdata_beef", 32'(last_rd0), 32'hBEEF);
    $display("txn read addr127 m0 rdata=%h", last_rd0);

    // m1 owns the port, drops req for one cycle while m0 requests.
    gnt_log.delete();
    q1.push_back(mk(1'b1, 1'b1, 20, 16'h1111));
    cycle();
    q1.push_back(mk(1'b1, 1'b1, 21, 16'h2222));
    q1.push_back(gap_txn());
    q1.push_back(mk(1'b0, 1'b0, 20, 0));
    q0.push_back(mk(1'b0, 1'b0, 21, 0));
    run(10);
    chk("own1_beat2", 32'(gnt_log[1]), 32'd1);
    chk("own1_drop_m0_gnt", 32'(gnt_log[2]), 32'd0);
    chk("own1_after_drop", 32'(gnt_log[3]), 32'd1);
    $display("txn ownership drop grants=%0d,%0d,%0d,%0d", gnt_log[0], gnt_log[1], gnt_log[2], gnt_log[3]);

    // Reset in the middle of a locked read burst with a read return pending.
    for (int i = 0; i < 4; i++) q0.push_back(mk(1'b0, 1'b1, 40 + i, 0));
    q1.push_back(mk(1'b1, 1'b0, 50, 16'h7777));
    cycle();
    cycle();
    chk("pre_reset_rvalid", 32'(m0_rvalid), 32'd1);
    reset = 1'b1;
    #1;
    chk_all_zero("mid_reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    q0.delete();
    q1.delete();
    model_reset();
    cycle();
    cycle();
    $display("txn mid-burst reset released, rvalid=%0b", m0_rvalid);

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (q0.size() == 0 && $urandom_range(0, 3) != 0) q0.push_back(rnd_txn());
      if (q1.size() == 0 && $urandom_range(0, 3) != 0) q1.push_back(rnd_txn());
      cycle();
    end
    run(100);
    cycle();
    $display("txn random phase done, cycles=400");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
